// File: rtl/timer_pkg.sv
// ============================================================================
// timer_pkg -- register map, CTRL bit positions and FSM state codes shared
//              by the timer controller and its register block.
// Revision: 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

  localparam logic [31:0] ADDR_CTRL   = 32'h00;
  localparam logic [31:0] ADDR_DIN    = 32'h04;
  localparam logic [31:0] ADDR_SAT    = 32'h08;
  localparam logic [31:0] ADDR_STATUS = 32'h0C;
  localparam logic [31:0] ADDR_COUNT  = 32'h10;

  localparam int CTRL_START    = 0;
  localparam int CTRL_STOP     = 1;
  localparam int CTRL_UP_DOWN  = 2;
  localparam int CTRL_MODE_LSB = 3;
  localparam int CTRL_ONESHOT  = 6;
  localparam int CTRL_IRQ_EN   = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RUN     = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_e;

endpackage

`default_nettype wire

// File: rtl/timer_regs.sv
// ============================================================================
// timer_regs -- APB decode, CTRL/DIN/SAT registers, read mux and error flag;
//               emits single-cycle start/stop/irq-clear command pulses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module timer_regs
  import timer_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pslverr,
  input  timer_state_e      state,
  input  logic              irq_pend,
  input  logic [31:0]       count,
  output logic              start_pulse,
  output logic              stop_pulse,
  output logic              irq_clr_pulse,
  output logic              up_down,
  output logic [2:0]        mode,
  output logic              oneshot,
  output logic              irq_en,
  output logic [31:0]       din,
  output logic [31:0]       sat
);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(ADDR_CTRL);
  localparam logic [ADDR_W-1:0] A_DIN    = ADDR_W'(ADDR_DIN);
  localparam logic [ADDR_W-1:0] A_SAT    = ADDR_W'(ADDR_SAT);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(ADDR_STATUS);
  localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(ADDR_COUNT);

  logic        sel_ctrl, sel_din, sel_sat, sel_status, sel_count, mapped;
  logic        wr_en, rd_en;
  logic        up_down_q, up_down_d, oneshot_q, oneshot_d, irq_en_q, irq_en_d;
  logic [2:0]  mode_q, mode_d;
  logic [31:0] din_q, din_d, sat_q, sat_d, ctrl_rd;

  always_comb begin
    sel_ctrl   = (paddr == A_CTRL);
    sel_din    = (paddr == A_DIN);
    sel_sat    = (paddr == A_SAT);
    sel_status = (paddr == A_STATUS);
    sel_count  = (paddr == A_COUNT);
    mapped     = sel_ctrl | sel_din | sel_sat | sel_status | sel_count;
    wr_en      = psel & penable & pwrite & mapped;
    rd_en      = psel & penable & ~pwrite;
    pslverr    = psel & penable & ~mapped;
  end

  // Command bits are not stored: they act only in the cycle they are written.
  assign start_pulse   = wr_en & sel_ctrl & pwdata[CTRL_START];
  assign stop_pulse    = wr_en & sel_ctrl & pwdata[CTRL_STOP];
  assign irq_clr_pulse = wr_en & sel_status & pwdata[0];

  always_comb begin
    up_down_d = up_down_q;
    mode_d    = mode_q;
    oneshot_d = oneshot_q;
    irq_en_d  = irq_en_q;
    din_d     = din_q;
    sat_d     = sat_q;
    if (wr_en && sel_ctrl) begin
      up_down_d = pwdata[CTRL_UP_DOWN];
      mode_d    = pwdata[CTRL_MODE_LSB +: 3];
      oneshot_d = pwdata[CTRL_ONESHOT];
      irq_en_d  = pwdata[CTRL_IRQ_EN];
    end
    if (wr_en && sel_din) din_d = pwdata;
    if (wr_en && sel_sat) sat_d = pwdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_down_q <= 1'b0;
      mode_q    <= 3'd0;
      oneshot_q <= 1'b0;
      irq_en_q  <= 1'b0;
      din_q     <= 32'd0;
      sat_q     <= 32'd0;
    end else begin
      up_down_q <= up_down_d;
      mode_q    <= mode_d;
      oneshot_q <= oneshot_d;
      irq_en_q  <= irq_en_d;
      din_q     <= din_d;
      sat_q     <= sat_d;
    end
  end

  always_comb begin
    ctrl_rd                         = 32'd0;
    ctrl_rd[CTRL_UP_DOWN]           = up_down_q;
    ctrl_rd[CTRL_MODE_LSB +: 3]     = mode_q;
    ctrl_rd[CTRL_ONESHOT]           = oneshot_q;
    ctrl_rd[CTRL_IRQ_EN]            = irq_en_q;
  end

  always_comb begin
    prdata = 32'd0;
    if (rd_en) begin
      if (sel_ctrl)        prdata = ctrl_rd;
      else if (sel_din)    prdata = din_q;
      else if (sel_sat)    prdata = sat_q;
      else if (sel_status) prdata = {28'd0, state, (state == ST_RUN), irq_pend};
      else if (sel_count)  prdata = count;
    end
  end

  assign up_down = up_down_q;
  assign mode    = mode_q;
  assign oneshot = oneshot_q;
  assign irq_en  = irq_en_q;
  assign din     = din_q;
  assign sat     = sat_q;

endmodule

`default_nettype wire

// File: rtl/timer_ctrl.sv
// ============================================================================
// timer_ctrl -- APB-programmed sequencer for one counter: start/stop/one-shot
//               FSM, timer_event edge detect and sticky maskable interrupt.
// Revision: 1.0
// ============================================================================
`default_nettype none

module timer_ctrl
  import timer_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              ctr_load,
  output logic              ctr_enable,
  output logic              ctr_up_down,
  output logic [2:0]        ctr_mode,
  output logic [31:0]       ctr_din,
  output logic [31:0]       ctr_sat,
  input  logic              timer_event,
  input  logic [31:0]       count,
  output logic              irq
);

  timer_state_e state_q, state_d;
  logic evt_q, evt_rise;
  logic irq_pend_q, irq_pend_d;
  logic ctr_load_q, ctr_enable_q;
  logic start_pulse, stop_pulse, irq_clr_pulse, oneshot, irq_en;

  timer_regs #(.ADDR_W(ADDR_W)) u_regs (
    .clk           (clk),
    .rst           (rst),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .prdata        (prdata),
    .pslverr       (pslverr),
    .state         (state_q),
    .irq_pend      (irq_pend_q),
    .count         (count),
    .start_pulse   (start_pulse),
    .stop_pulse    (stop_pulse),
    .irq_clr_pulse (irq_clr_pulse),
    .up_down       (ctr_up_down),
    .mode          (ctr_mode),
    .oneshot       (oneshot),
    .irq_en        (irq_en),
    .din           (ctr_din),
    .sat           (ctr_sat)
  );

  // Edges outside RUN are dropped so a stale event cannot re-arm the interrupt.
  assign evt_rise = timer_event & ~evt_q & (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD:    state_d = ST_RUN;
      ST_RUN:     if (evt_rise && oneshot) state_d = ST_EXPIRED;
      default:    state_d = state_q;
    endcase
    if (start_pulse) state_d = ST_LOAD;
    if (stop_pulse)  state_d = ST_IDLE;
  end

  // A new event in the same cycle as a W1C still leaves the interrupt pending.
  always_comb begin
    irq_pend_d = irq_pend_q;
    if (irq_clr_pulse) irq_pend_d = 1'b0;
    if (evt_rise)      irq_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      evt_q        <= 1'b0;
      irq_pend_q   <= 1'b0;
      ctr_load_q   <= 1'b0;
      ctr_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      evt_q        <= timer_event;
      irq_pend_q   <= irq_pend_d;
      ctr_load_q   <= (state_d == ST_LOAD);
      ctr_enable_q <= (state_d == ST_RUN);
    end
  end

  assign ctr_load   = ctr_load_q;
  assign ctr_enable = ctr_enable_q;
  assign pready     = 1'b1;
  assign irq        = irq_pend_q & irq_en;

endmodule

`default_nettype wire

// File: tb/tb_timer_ctrl.sv
// ============================================================================
// tb_timer_ctrl -- directed, table-driven bench for timer_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [4:0]  paddr = 5'd0;
  logic [31:0] pwdata = 32'd0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        ctr_load, ctr_enable, ctr_up_down;
  logic [2:0]  ctr_mode;
  logic [31:0] ctr_din, ctr_sat;
  logic        timer_event = 1'b0;
  logic [31:0] count = 32'h0000_1234;
  logic        irq;

  int passed = 0;
  int total  = 0;

  timer_ctrl #(.ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .ctr_load(ctr_load), .ctr_enable(ctr_enable),
    .ctr_up_down(ctr_up_down), .ctr_mode(ctr_mode), .ctr_din(ctr_din),
    .ctr_sat(ctr_sat), .timer_event(timer_event), .count(count), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  // Returns one ns after the commit edge; evt raises timer_event in the access cycle.
  task automatic apb(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                     input logic evt, output logic [31:0] rd, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    if (evt) timer_event = 1'b1;
    #3;
    rd  = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr32(input logic [4:0] addr, input logic [31:0] wd);
    logic [31:0] rd; logic err;
    apb(1'b1, addr, wd, 1'b0, rd, err);
  endtask

  task automatic rd_check(input string name, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] rd; logic err;
    apb(1'b0, addr, 32'd0, 1'b0, rd, err);
    check(name, rd, exp);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;

    vecs[0]  = '{1'b1, 5'h04, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 5'h04, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 5'h08, 32'h0000000A, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 5'h08, 32'h0,        32'h0000000A, 1'b0};
    vecs[4]  = '{1'b1, 5'h00, 32'h000000FC, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 5'h00, 32'h0,        32'h000000FC, 1'b0};
    vecs[6]  = '{1'b1, 5'h00, 32'h000000FE, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 5'h00, 32'h0,        32'h000000FC, 1'b0};
    vecs[8]  = '{1'b1, 5'h10, 32'h0000FFFF, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 5'h10, 32'h0,        32'h00001234, 1'b0};
    vecs[10] = '{1'b0, 5'h14, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b1, 5'h18, 32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 5'h0C, 32'h0,        32'h0,        1'b0};
    vecs[13] = '{1'b0, 5'h1C, 32'h0,        32'h0,        1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_load",   {31'd0, ctr_load},   32'd0);
    check("rst_enable", {31'd0, ctr_enable}, 32'd0);
    check("rst_irq",    {31'd0, irq},        32'd0);
    check("rst_din",    ctr_din,             32'd0);
    check("rst_mode",   {29'd0, ctr_mode},   32'd0);
    rst = 1'b1;
    tick();
    check("rst_pready", {31'd0, pready},     32'd1);
    check("rst_prdata", prdata,              32'd0);
    check("rst_slverr", {31'd0, pslverr},    32'd0);
    rd_check("rst_status", 5'h0C, 32'h0);

    // Bus vectors
    for (int i = 0; i < 14; i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, err);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_slverr", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
    end
    check("bus_din",    ctr_din,                32'hDEADBEEF);
    check("bus_sat",    ctr_sat,                32'h0000000A);
    check("bus_mode",   {29'd0, ctr_mode},      32'd7);
    check("bus_updown", {31'd0, ctr_up_down},   32'd1);
    check("bus_idle_en",{31'd0, ctr_enable},    32'd0);

    // Periodic up-count
    wr32(5'h04, 32'd0);
    wr32(5'h08, 32'd10);
    wr32(5'h00, 32'h0000008D);
    check("per_load1",  {31'd0, ctr_load},   32'd1);
    check("per_en0",    {31'd0, ctr_enable}, 32'd0);
    check("per_mode",   {29'd0, ctr_mode},   32'd1);
    tick();
    check("per_load0",  {31'd0, ctr_load},   32'd0);
    check("per_en1",    {31'd0, ctr_enable}, 32'd1);
    timer_event = 1'b1;
    check("per_irq_pre", {31'd0, irq},       32'd0);
    tick();
    timer_event = 1'b0;
    check("per_irq1",   {31'd0, irq},        32'd1);
    check("per_en_hold",{31'd0, ctr_enable}, 32'd1);
    wr32(5'h0C, 32'h1);
    check("per_irq_clr",{31'd0, irq},        32'd0);
    timer_event = 1'b1;
    tick();
    timer_event = 1'b0;
    check("per_irq2",   {31'd0, irq},        32'd1);
    rd_check("per_status", 5'h0C, 32'hB);

    // W1C racing an event edge: set wins
    wr32(5'h0C, 32'h1);
    check("race_pre",   {31'd0, irq},        32'd0);
    apb(1'b1, 5'h0C, 32'h1, 1'b1, rd, err);
    timer_event = 1'b0;
    check("race_irq",   {31'd0, irq},        32'd1);
    rd_check("race_status", 5'h0C, 32'hB);
    wr32(5'h0C, 32'h1);
    check("clean_clr",  {31'd0, irq},        32'd0);
    rd_check("clean_status", 5'h0C, 32'hA);

    // START and STOP together in RUN
    wr32(5'h00, 32'h0000008F);
    check("ss_load",    {31'd0, ctr_load},   32'd0);
    check("ss_enable",  {31'd0, ctr_enable}, 32'd0);
    tick();
    check("ss_load2",   {31'd0, ctr_load},   32'd0);
    rd_check("ss_status", 5'h0C, 32'h0);

    // One-shot down-count
    wr32(5'h04, 32'd20);
    wr32(5'h00, 32'h000000D9);
    check("os_load",    {31'd0, ctr_load},    32'd1);
    check("os_din",     ctr_din,              32'd20);
    check("os_mode",    {29'd0, ctr_mode},    32'd3);
    check("os_updown",  {31'd0, ctr_up_down}, 32'd0);
    tick();
    check("os_en1",     {31'd0, ctr_enable},  32'd1);
    timer_event = 1'b1;
    tick();
    timer_event = 1'b0;
    check("os_en0",     {31'd0, ctr_enable},  32'd0);
    check("os_irq",     {31'd0, irq},         32'd1);
    rd_check("os_status", 5'h0C, 32'hD);
    wr32(5'h0C, 32'h1);
    timer_event = 1'b1;
    tick();
    timer_event = 1'b0;
    tick();
    check("os_exp_ign", {31'd0, irq},         32'd0);
    rd_check("os_exp_status", 5'h0C, 32'hC);
    wr32(5'h00, 32'h000000D9);
    check("os_reload",  {31'd0, ctr_load},    32'd1);
    tick();
    check("os_rerun",   {31'd0, ctr_enable},  32'd1);
    rd_check("os_run_status", 5'h0C, 32'hA);

    // Asynchronous reset mid-RUN with an interrupt pending
    wr32(5'h00, 32'h0000008D);
    tick();
    timer_event = 1'b1;
    tick();
    timer_event = 1'b0;
    check("ar_irq_pre", {31'd0, irq},         32'd1);
    rst = 1'b0;
    #2;
    check("ar_irq",     {31'd0, irq},         32'd0);
    check("ar_enable",  {31'd0, ctr_enable},  32'd0);
    check("ar_load",    {31'd0, ctr_load},    32'd0);
    check("ar_din",     ctr_din,              32'd0);
    check("ar_sat",     ctr_sat,              32'd0);
    check("ar_mode",    {29'd0, ctr_mode},    32'd0);
    tick();
    rst = 1'b1;
    rd_check("ar_status", 5'h0C, 32'h0);
    rd_check("ar_ctrl",   5'h00, 32'h0);
    rd_check("ar_count",  5'h10, 32'h1234);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timer_ctrl.md
# timer_ctrl

Register-programmed controller for the `counter` timer block: it sits between an APB bus and one `counter` instance. It drives the counter's configuration inputs (`load`, `din`, `mode`, `up_down`, `enable`, `sat_count`) and consumes its `timer_event` and `count` outputs. It turns `timer_event` into a sticky, maskable interrupt and sequences start, stop and one-shot expiry with a small FSM.

## Interface
- `ADDR_W`, 5: APB address width (byte addresses, word aligned).
- `clk` in 1: single clock, shared with `counter`.
- `rst` in 1: asynchronous, active-low reset.
- `psel`, `penable`, `pwrite` in 1 each: APB control.
- `paddr` in ADDR_W: register address.
- `pwdata` in 32: write data.
- `prdata` out 32: read data.
- `pready` out 1: tied 1, no wait states.
- `pslverr` out 1: error flag for unmapped addresses.
- `ctr_load`, `ctr_enable`, `ctr_up_down` out 1 each: to `counter` `load`, `enable`, `up_down`.
- `ctr_mode` out 3: to `counter` `mode` (step = mode+1).
- `ctr_din`, `ctr_sat` out 32: to `counter` `din`, `sat_count`.
- `timer_event` in 1: from `counter`.
- `count` in 32: from `counter`, used for readback only.
- `irq` out 1: interrupt, `irq_pend & irq_en`.

## Operation
- Register map:
  - 0x00 CTRL: b0 START (write-only, reads 0), b1 STOP (write-only, reads 0), b2 UP_DOWN, b5:3 MODE, b6 ONESHOT, b7 IRQ_EN.
  - 0x04 DIN.
  - 0x08 SAT.
  - 0x0C STATUS: b0 IRQ_PEND (write 1 to clear), b1 RUNNING, b3:2 state code.
  - 0x10 COUNT, read-only; writes are ignored with no error.
- Any other address sets `pslverr=1` during the access phase. Writes to it have no effect and reads return 0.
- `ctr_din`, `ctr_sat`, `ctr_mode` and `ctr_up_down` are driven straight from the registers. A write while running takes effect on the counter on the next cycle.
- FSM states, codes in STATUS[3:2]:
  - IDLE=0: `ctr_enable=0`.
  - LOAD=1: `ctr_load=1` for exactly one cycle, `ctr_enable=0`.
  - RUN=2: `ctr_enable=1`.
  - EXPIRED=3: `ctr_enable=0`; `count` holds its value.
- Transitions:
  - START from any state goes to LOAD.
  - LOAD always goes to RUN on the next cycle.
  - In RUN, an event edge with ONESHOT=1 goes to EXPIRED. With ONESHOT=0 it stays in RUN, and the counter wraps or reloads by itself.
  - STOP from any state goes to IDLE.
  - START and STOP in the same write: STOP wins.
- Event edge: `evt_rise = timer_event & ~evt_q`, where `evt_q` is `timer_event` registered. It is qualified only in RUN; edges in other states are ignored.
- IRQ_PEND is set by a qualified `evt_rise`. It is cleared by writing 1 to STATUS b0. If the set and the clear land in the same cycle, the set wins.
- RUNNING = (state == RUN).

## Timing
- Reset values:
  - All registers 0 and state IDLE.
  - `ctr_load`, `ctr_enable`, `irq`, `pslverr` are 0; `ctr_din`, `ctr_sat` are 0; `ctr_mode` is 0.
  - `prdata` is 0 outside the access phase.
- Write commit: on the `clk` edge where `psel & penable & pwrite`. The new value is visible from the following cycle.
- Read: `prdata` is combinational during `psel & penable & ~pwrite`.
- START write at edge N:
  - `ctr_load=1` in cycle N+1.
  - `ctr_enable=1` from cycle N+2.
- `timer_event` rising in cycle M (in RUN):
  - IRQ_PEND=1 and `irq` (if enabled) high from cycle M+1.
  - With ONESHOT=1, `ctr_enable` is low from cycle M+1.
- STOP write at edge N: `ctr_enable=0` from cycle N+1.
- Asserting `rst` mid-operation forces IDLE and clears IRQ_PEND immediately, without waiting for a clock edge.

## Structure
- `timer_pkg` holds:
  - the address localparams;
  - the `timer_state_e` enum {IDLE, LOAD, RUN, EXPIRED} with explicit 2-bit codes;
  - the CTRL bit-position constants.
- Sub-module `timer_regs` holds the APB decode, the CTRL/DIN/SAT registers, the read mux and `pslverr`. It outputs `start_pulse`, `stop_pulse` and `irq_clr_pulse`.
- The top level holds the FSM, event edge detection and IRQ_PEND.

## Test plan
- Reset: assert `rst=0` mid-RUN, then release. Required: state IDLE, all outputs 0, STATUS reads 0x0.
- Periodic up-count:
  - Setup: DIN=0, SAT=10, MODE=1, UP_DOWN=1, IRQ_EN=1, START.
  - Required: one `ctr_load` pulse, then `ctr_enable` stays 1.
  - Required: `irq` rises one cycle after each `timer_event` rise, and the state remains RUN.
- One-shot down-count:
  - Setup: DIN=20, MODE=3, ONESHOT=1, START.
  - Required: on the first event edge, `ctr_enable` drops and STATUS reads state=3, IRQ_PEND=1.
  - Required: a later START returns to LOAD, then RUN.
- W1C race: a STATUS write of 0x1 in the same cycle as an event edge leaves IRQ_PEND=1. A clean write of 0x1 clears it and drops `irq`.
- CTRL write with START and STOP both set in RUN: required next state IDLE and no `ctr_load` pulse.
- Bus:
  - Read 0x14: `pslverr=1`, `prdata=0`.
  - Write 0x10: no effect.
  - Read 0x10 while counter `count=0x1234`: returns 0x1234.
